// File: rtl/pad_stream_gen.sv
// One-time-pad keystream generator: a Galois LFSR advanced STEPS times per word,
// emitting a counted run of key words over a valid/ready handshake.
module pad_stream_gen #(
    parameter int                 WIDTH = 32,
    parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(32'h80200003),
    parameter int                 STEPS = 8,
    parameter int                 LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             start,
    input  logic [LEN_W-1:0] pad_len,
    input  logic             abort,
    output logic [WIDTH-1:0] key,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             busy,
    output logic             done,
    output logic             seed_err,
    output logic [1:0]       state_dbg,
    output logic [WIDTH-1:0] lfsr_dbg
);

    // Handshake: a word transfers on any rising edge where key_valid & key_ready;
    // key and key_valid stay stable until then, and key_valid never depends on key_ready.

    localparam int            SW   = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [SW-1:0]    step_cnt_q, step_cnt_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             key_valid_q, key_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             seed_err_q, seed_err_d;
    logic [WIDTH-1:0] lfsr_step;

    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= '1;
            key_q       <= '0;
            step_cnt_q  <= '0;
            remaining_q <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seed_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            key_q       <= key_d;
            step_cnt_q  <= step_cnt_d;
            remaining_q <= remaining_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            seed_err_q  <= seed_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        key_d       = key_q;
        step_cnt_d  = step_cnt_q;
        remaining_d = remaining_q;
        key_valid_d = key_valid_q;
        seed_err_d  = seed_err_q;

        if (abort) begin
            // LFSR is deliberately left alone so the next pad resumes the stream.
            state_d     = IDLE;
            key_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        lfsr_d     = (seed == '0) ? '1 : seed;
                        seed_err_d = (seed == '0);
                    end
                    if (start) begin
                        if (pad_len != '0) begin
                            remaining_d = pad_len;
                            step_cnt_d  = '0;
                            state_d     = RUN;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                RUN: begin
                    lfsr_d = lfsr_step;
                    if (step_cnt_q == LAST) begin
                        key_d       = lfsr_step;
                        key_valid_d = 1'b1;
                        step_cnt_d  = '0;
                        state_d     = HOLD;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (key_ready) begin
                        key_valid_d = 1'b0;
                        remaining_d = remaining_q - 1'b1;
                        step_cnt_d  = '0;
                        state_d     = (remaining_q == LEN_W'(1)) ? DONE : RUN;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // busy and done are registered views of the state being entered.
        busy_d = (state_d == RUN) || (state_d == HOLD);
        done_d = (state_d == DONE);
    end

    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign seed_err  = seed_err_q;
    assign state_dbg = state_q;
    assign lfsr_dbg  = lfsr_q;

endmodule
